// File: rtl/booth_seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// controller state encoding and iteration counter width.
package booth_div_pkg;

    localparam int DIV_N     = 8;
    localparam int DIV_CNT_W = $clog2(2 * DIV_N);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/booth_seq_divider_if.sv
// Operand/result handshake bundle of the divider. The master drives operands
// and accepts results; the slave (the divider) does the opposite.
interface booth_seq_divider_if
    import booth_div_pkg::*;
    #(parameter int N = DIV_N)
    ();

    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           ovf;
    logic           dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dz
    );

endinterface

// File: rtl/booth_seq_divider_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and trial-subtract the divisor magnitude with a ripple borrow chain.
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   prem,
    input  logic         qmsb,
    input  logic [N-1:0] dmag,
    output logic [N:0]   prem_nxt,
    output logic         qbit
);

    logic [N:0] shifted_s;
    logic [N:0] subtr_s;
    logic [N:0] diff_s;
    logic       borrow_s;

    // Ripple subtractor; a bit shifted out of the top guarantees the trial fits.
    always_comb begin
        logic brw;
        shifted_s = {prem[N-1:0], qmsb};
        subtr_s   = {1'b0, dmag};
        diff_s    = {(N+1){1'b0}};
        brw       = 1'b0;
        for (int i = 0; i <= N; i++) begin
            diff_s[i] = shifted_s[i] ^ subtr_s[i] ^ brw;
            brw       = (~shifted_s[i] & subtr_s[i]) |
                        (~(shifted_s[i] ^ subtr_s[i]) & brw);
        end
        borrow_s = brw & ~prem[N];
        if (borrow_s) begin
            prem_nxt = shifted_s;
            qbit     = 1'b0;
        end else begin
            prem_nxt = diff_s;
            qbit     = 1'b1;
        end
    end

endmodule

// File: rtl/booth_seq_divider.sv
// Multi-cycle signed divider (2N-bit dividend / N-bit divisor), truncating
// toward zero, one restoring quotient bit per clock, saturating on overflow.
module booth_seq_divider
    import booth_div_pkg::*;
    #(parameter int N = DIV_N)
    (
    input logic               clk,
    input logic               rst_n,
    booth_seq_divider_if.slave bus
);

    localparam int CW = (N == DIV_N) ? DIV_CNT_W : $clog2(2 * N);
    localparam logic [CW-1:0]    CNT_LAST = CW'(2 * N - 1);
    localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [2*N-1:0]   QPOS_MAX = (2*N)'((1 << (N - 1)) - 1);
    localparam logic [2*N-1:0]   QNEG_MAX = (2*N)'(1 << (N - 1));
    localparam logic [N-1:0]     SAT_POS  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]     SAT_NEG  = {1'b1, {(N-1){1'b0}}};

    div_state_e     state_r;
    logic [2*N-1:0] dvd_r;
    logic [N-1:0]   dsr_r;
    logic           sq_r;
    logic           sr_r;
    logic           zdiv_r;
    logic [N-1:0]   dmag_r;
    logic [N:0]     prem_r;
    logic [2*N-1:0] qreg_r;
    logic [CW-1:0]  cnt_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [N-1:0]   quotient_r;
    logic [N-1:0]   remainder_r;
    logic           ovf_r;
    logic           dz_r;

    logic [2*N-1:0] dvd_mag_s;
    logic [N-1:0]   dsr_mag_s;
    logic [N:0]     prem_nxt_s;
    logic           qbit_s;
    logic           ovf_s;
    logic [N-1:0]   quot_s;
    logic [N-1:0]   rem_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.ovf       = ovf_r;
    assign bus.dz        = dz_r;

    // Operand magnitudes; the most negative value maps to its unsigned magnitude.
    always_comb begin
        dvd_mag_s = dvd_r;
        dsr_mag_s = dsr_r;
        if (dvd_r[2*N-1]) begin
            dvd_mag_s = -dvd_r;
        end else begin
            dvd_mag_s = dvd_r;
        end
        if (dsr_r[N-1]) begin
            dsr_mag_s = -dsr_r;
        end else begin
            dsr_mag_s = dsr_r;
        end
    end

    div_step #(.N(N)) u_step (
        .prem     (prem_r),
        .qmsb     (qreg_r[2*N-1]),
        .dmag     (dmag_r),
        .prem_nxt (prem_nxt_s),
        .qbit     (qbit_s)
    );

    // Sign fix-up, overflow detection and saturation of the finished quotient.
    always_comb begin
        ovf_s  = 1'b0;
        quot_s = {N{1'b0}};
        rem_s  = {N{1'b0}};
        if (zdiv_r) begin
            quot_s = {N{1'b0}};
            rem_s  = dvd_r[N-1:0];
            ovf_s  = 1'b0;
        end else begin
            if (sq_r) begin
                ovf_s = (qreg_r > QNEG_MAX);
            end else begin
                ovf_s = (qreg_r > QPOS_MAX);
            end
            if (ovf_s) begin
                quot_s = sq_r ? SAT_NEG : SAT_POS;
            end else if (sq_r) begin
                quot_s = -qreg_r[N-1:0];
            end else begin
                quot_s = qreg_r[N-1:0];
            end
            // Remainder magnitude is below |divisor| so it always fits in N bits.
            if (sr_r) begin
                rem_s = -prem_r[N-1:0];
            end else begin
                rem_s = prem_r[N-1:0];
            end
        end
    end

    // Controller FSM with all datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            dvd_r       <= {(2*N){1'b0}};
            dsr_r       <= {N{1'b0}};
            sq_r        <= 1'b0;
            sr_r        <= 1'b0;
            zdiv_r      <= 1'b0;
            dmag_r      <= {N{1'b0}};
            prem_r      <= {(N+1){1'b0}};
            qreg_r      <= {(2*N){1'b0}};
            cnt_r       <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {N{1'b0}};
            remainder_r <= {N{1'b0}};
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        dvd_r      <= bus.dividend;
                        dsr_r      <= bus.divisor;
                        sq_r       <= bus.dividend[2*N-1] ^ bus.divisor[N-1];
                        sr_r       <= bus.dividend[2*N-1];
                        in_ready_r <= 1'b0;
                        state_r    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    dmag_r <= dsr_mag_s;
                    if (dsr_r == {N{1'b0}}) begin
                        zdiv_r  <= 1'b1;
                        state_r <= ST_FIX;
                    end else begin
                        zdiv_r  <= 1'b0;
                        prem_r  <= {(N+1){1'b0}};
                        qreg_r  <= dvd_mag_s;
                        cnt_r   <= CNT_LAST;
                        state_r <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    prem_r <= prem_nxt_s;
                    qreg_r <= {qreg_r[2*N-2:0], qbit_s};
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_FIX: begin
                    quotient_r  <= quot_s;
                    remainder_r <= rem_s;
                    ovf_r       <= ovf_s;
                    dz_r        <= zdiv_r;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Scoreboard bench for booth_seq_divider: expected results are queued when
// operands are driven and compared when the divider presents its result.
module tb_booth_seq_divider;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       dz;
        int         lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    booth_seq_divider_if #(.N(8)) bus ();

    booth_seq_divider #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t m;
        int a, b, qt, rt;
        a = int'($signed(dvd));
        b = int'($signed(dvs));
        if (b == 0) begin
            m.q = 8'h00; m.r = dvd[7:0]; m.ovf = 1'b0; m.dz = 1'b1; m.lat = 2;
        end else begin
            qt = a / b;
            rt = a % b;
            m.dz = 1'b0; m.lat = 18; m.r = rt[7:0];
            if (qt > 127) begin
                m.ovf = 1'b1; m.q = 8'h7F;
            end else if (qt < -128) begin
                m.ovf = 1'b1; m.q = 8'h80;
            end else begin
                m.ovf = 1'b0; m.q = qt[7:0];
            end
        end
        return m;
    endfunction

    task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs, input int hold);
        exp_t e;
        int   lat;
        logic [17:0] snap;
        sb.push_back(model(dvd, dvs));
        @(negedge clk);
        chk_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        e = sb.pop_front();
        if (lat == 0) begin
            chk_eq("out_valid_timeout", 32'd0, 32'd1);
        end else begin
            chk_eq("latency", 32'(lat), 32'(e.lat));
            chk_eq("quotient", 32'(bus.quotient), 32'(e.q));
            chk_eq("remainder", 32'(bus.remainder), 32'(e.r));
            chk_eq("ovf", 32'(bus.ovf), 32'(e.ovf));
            chk_eq("dz", 32'(bus.dz), 32'(e.dz));
            snap = {bus.quotient, bus.remainder, bus.ovf, bus.dz};
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk_eq("hold_outputs", 32'({bus.quotient, bus.remainder, bus.ovf, bus.dz}), 32'(snap));
                chk_eq("hold_valid", 32'(bus.out_valid), 32'd1);
                chk_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            chk_eq("retire_valid", 32'(bus.out_valid), 32'd0);
            chk_eq("retire_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] rd;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = 16'h0000;
        bus.divisor   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("rst_outputs", 32'({bus.quotient, bus.remainder, bus.ovf, bus.dz}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h0064, 8'h07, 0);
        do_op(16'hFF7C, 8'h0B, 10);
        do_op(16'hFF9C, 8'h07, 0);
        do_op(16'h7FFF, 8'h01, 0);
        do_op(16'hC000, 8'h80, 0);
        do_op(16'hFF80, 8'h01, 0);
        do_op(16'h8000, 8'hFF, 0);
        do_op(16'h1234, 8'h00, 3);
        do_op(16'h0064, 8'hF9, 0);

        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (k % 3 == 0) begin
                rd = 16'($signed(ra) * $signed(rb));
            end else begin
                rd = 16'($urandom);
            end
            if (k % 8 == 5) begin
                rb = 8'h00;
            end
            do_op(rd, rb, k % 2);
        end

        // Abort an operation in the middle of the iteration phase.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 16'h0064;
        bus.divisor  = 8'h07;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk_eq("abort_outputs", 32'({bus.quotient, bus.remainder, bus.ovf, bus.dz}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0064, 8'h07, 0);

        chk_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
